// File: rtl/neuron_mac_seq_if.sv
// Bus bundle between the MAC neuron, its weight/feature BRAMs and the
// downstream consumer of the activation. The neuron sits on the slave side.
interface neuron_mac_seq_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] bias;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic [DATA_W-1:0] w_do;
  logic [DATA_W-1:0] x_do;
  logic [DATA_W-1:0] y;
  logic              y_valid;
  logic              y_ready;

  modport slave (
    input  start, bias, w_do, x_do, y_ready,
    output busy, addr, en, y, y_valid
  );

  modport master (
    output start, bias, w_do, x_do, y_ready,
    input  busy, addr, en, y, y_valid
  );
endinterface

// File: rtl/neuron_mac_seq.sv
// Sequenced multiply-accumulate neuron: walks both BRAMs, accumulates
// weight*feature, adds bias, rounds half-up, saturates and optionally
// applies ReLU. Result is offered on a valid/ready output.
module neuron_mac_seq #(
  parameter int N_IN      = 28,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter bit RELU_EN   = 1'b1
) (
  input logic              clk,
  input logic              rst,
  neuron_mac_seq_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, FINAL, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ROUND_HALF =
    {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

  state_t state, state_next;
  logic   accept, last_fetch, load_y, xfer;

  logic [ADDR_W-1:0]          addr_q;
  logic                       en_q;
  logic signed [2*DATA_W-1:0] prod_q;
  logic                       prod_valid_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [DATA_W-1:0]   bias_q;
  logic [DATA_W-1:0]          y_q;
  logic                       y_valid_q;

  logic signed [ACC_W-1:0] prod_ext, bias_ext, sum, shifted;
  logic [DATA_W-1:0]       y_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and one-cycle control strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_fetch = 1'b0;
    load_y     = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE:  if (bus.start) begin
               accept     = 1'b1;
               state_next = FETCH;
             end
      FETCH: if (addr_q == LAST_ADDR) begin
               last_fetch = 1'b1;
               state_next = DRAIN;
             end
      // The last product is still waiting to be accumulated here
      DRAIN: state_next = FINAL;
      FINAL: begin
               load_y     = 1'b1;
               state_next = DONE;
             end
      DONE:  if (y_valid_q && bus.y_ready) begin
               xfer       = 1'b1;
               state_next = IDLE;
             end
      default: state_next = IDLE;
    endcase
  end

  // BRAM address walk; address parks at 0 whenever reads are disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      en_q   <= 1'b0;
    end else if (accept) begin
      addr_q <= '0;
      en_q   <= 1'b1;
    end else if (last_fetch) begin
      addr_q <= '0;
      en_q   <= 1'b0;
    end else if (en_q) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // Product stage then accumulate stage; en delayed one cycle marks valid products
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      acc_q        <= '0;
      bias_q       <= '0;
    end else begin
      prod_valid_q <= en_q;
      if (en_q) prod_q <= $signed(bus.w_do) * $signed(bus.x_do);
      if (accept) begin
        acc_q  <= '0;
        bias_q <= $signed(bus.bias);
      end else if (prod_valid_q) begin
        acc_q <= acc_q + prod_ext;
      end
    end
  end

  // Bias, round half-up, saturate and optional ReLU
  always_comb begin
    prod_ext = {{(ACC_W-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};
    bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
    sum      = acc_q + (bias_ext <<< FRAC_BITS) + ROUND_HALF;
    shifted  = sum >>> FRAC_BITS;
    if (shifted > Y_MAX)      y_next = Y_MAX[DATA_W-1:0];
    else if (shifted < Y_MIN) y_next = Y_MIN[DATA_W-1:0];
    else                      y_next = shifted[DATA_W-1:0];
    if (RELU_EN && shifted[ACC_W-1]) y_next = '0;
  end

  // Output register; Y holds its value after the transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else if (load_y) begin
      y_q       <= y_next;
      y_valid_q <= 1'b1;
    end else if (xfer) begin
      y_valid_q <= 1'b0;
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.addr    = addr_q;
  assign bus.en      = en_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: ReLU and linear 28-input instances
// share stimulus; a 1-input linear instance covers the short-job latency.
module tb_neuron_mac_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start_s;
  logic [15:0] bias;
  logic        y_ready;

  logic [15:0] w_mem [0:31];
  logic [15:0] x_mem [0:31];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [15:0] w;
    logic [15:0] x;
    bit          only0;
    logic [15:0] b;
    logic [15:0] exp_r;
    logic [15:0] exp_l;
  } vec_t;

  vec_t vecs[$];

  neuron_mac_seq_if #(.ADDR_W(5), .DATA_W(16)) bus_r ();
  neuron_mac_seq_if #(.ADDR_W(5), .DATA_W(16)) bus_l ();
  neuron_mac_seq_if #(.ADDR_W(5), .DATA_W(16)) bus_s ();

  neuron_mac_seq #(.N_IN(28), .ADDR_W(5), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40), .RELU_EN(1'b1))
    dut_r (.clk(clk), .rst(rst), .bus(bus_r));
  neuron_mac_seq #(.N_IN(28), .ADDR_W(5), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40), .RELU_EN(1'b0))
    dut_l (.clk(clk), .rst(rst), .bus(bus_l));
  neuron_mac_seq #(.N_IN(1), .ADDR_W(5), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40), .RELU_EN(1'b0))
    dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  assign bus_r.start   = start;
  assign bus_l.start   = start;
  assign bus_s.start   = start_s;
  assign bus_r.bias    = bias;
  assign bus_l.bias    = bias;
  assign bus_s.bias    = bias;
  assign bus_r.y_ready = y_ready;
  assign bus_l.y_ready = y_ready;
  assign bus_s.y_ready = y_ready;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models: read data registered on the falling edge
  always @(negedge clk) begin
    if (bus_r.en) begin
      bus_r.w_do <= w_mem[bus_r.addr];
      bus_r.x_do <= x_mem[bus_r.addr];
    end
    if (bus_l.en) begin
      bus_l.w_do <= w_mem[bus_l.addr];
      bus_l.x_do <= x_mem[bus_l.addr];
    end
    if (bus_s.en) begin
      bus_s.w_do <= w_mem[bus_s.addr];
      bus_s.x_do <= x_mem[bus_s.addr];
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic load_mem(input logic [15:0] w, input logic [15:0] x, input bit only0);
    for (int i = 0; i < 32; i++) begin
      if ((only0 && i != 0) || i >= 28) begin
        w_mem[i] = 16'h0000;
        x_mem[i] = 16'h0000;
      end else begin
        w_mem[i] = w;
        x_mem[i] = x;
      end
    end
  endtask

  task automatic add_vec(input string name, input logic [15:0] w, input logic [15:0] x,
                         input bit only0, input logic [15:0] b,
                         input logic [15:0] exp_r, input logic [15:0] exp_l);
    vec_t v;
    v.name = name; v.w = w; v.x = x; v.only0 = only0;
    v.b = b; v.exp_r = exp_r; v.exp_l = exp_l;
    vecs.push_back(v);
  endtask

  // Waits (bounded) for y_valid on the ReLU instance; returns posedges since accept
  task automatic wait_valid(output int cyc, output int addr_err);
    cyc = 0;
    addr_err = 0;
    while (!bus_r.y_valid && cyc < 200) begin
      if (cyc < 28) begin
        if (!(bus_r.en === 1'b1 && bus_r.addr === 5'(cyc))) addr_err++;
      end else begin
        if (!(bus_r.en === 1'b0 && bus_r.addr === 5'd0)) addr_err++;
      end
      tick();
      cyc++;
    end
  endtask

  // One full job with y_ready high: start, wait, check result and transfer
  task automatic apply_stimulus(input string name, input logic [15:0] b,
                                input logic [15:0] exp_r, input logic [15:0] exp_l);
    int cyc, addr_err;
    bias  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    bias  = ~b;
    check_output({name, "_busy"}, 32'(bus_r.busy), 32'd1);
    wait_valid(cyc, addr_err);
    check_output({name, "_latency"}, 32'(cyc), 32'd30);
    check_output({name, "_addr_seq"}, 32'(addr_err), 32'd0);
    check_output({name, "_y_relu"}, 32'(bus_r.y), 32'(exp_r));
    check_output({name, "_y_lin"}, 32'(bus_l.y), 32'(exp_l));
    check_output({name, "_valid_lin"}, 32'(bus_l.y_valid), 32'd1);
    tick();
    check_output({name, "_post_xfer"}, 32'({bus_r.busy, bus_r.y_valid}), 32'd0);
    check_output({name, "_y_hold"}, 32'(bus_r.y), 32'(exp_r));
  endtask

  initial begin
    int cyc, addr_err, err, hits;

    rst = 1'b1; start = 1'b0; start_s = 1'b0; bias = 16'h0000; y_ready = 1'b1;
    load_mem(16'h0000, 16'h0000, 1'b0);

    add_vec("unity",    16'h0100, 16'h0100, 1'b0, 16'h0000, 16'h1C00, 16'h1C00);
    add_vec("bias",     16'h0100, 16'h0100, 1'b0, 16'h0100, 16'h1D00, 16'h1D00);
    add_vec("pos_sat",  16'h7FFF, 16'h7FFF, 1'b0, 16'h0000, 16'h7FFF, 16'h7FFF);
    add_vec("neg",      16'hFF00, 16'h0100, 1'b0, 16'h0000, 16'h0000, 16'hE400);
    add_vec("neg_sat",  16'h8000, 16'h7FFF, 1'b0, 16'h0000, 16'h0000, 16'h8000);
    add_vec("min_sq",   16'h8000, 16'h8000, 1'b0, 16'h8000, 16'h7FFF, 16'h7FFF);
    add_vec("bias_neg", 16'h0000, 16'h0000, 1'b0, 16'hFF00, 16'h0000, 16'hFF00);
    add_vec("round_up", 16'h0080, 16'h0001, 1'b1, 16'h0000, 16'h0001, 16'h0001);
    add_vec("round_dn", 16'h0080, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    add_vec("neg_half", 16'hFF80, 16'h0001, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    add_vec("neg_lsb",  16'hFF7F, 16'h0001, 1'b1, 16'h0000, 16'h0000, 16'hFFFF);

    tick(); tick();
    rst = 1'b0;
    check_output("reset_r", 32'({bus_r.busy, bus_r.en, bus_r.addr, bus_r.y, bus_r.y_valid}), 32'd0);
    check_output("reset_l", 32'({bus_l.busy, bus_l.en, bus_l.addr, bus_l.y, bus_l.y_valid}), 32'd0);
    check_output("reset_s", 32'({bus_s.busy, bus_s.en, bus_s.addr, bus_s.y, bus_s.y_valid}), 32'd0);

    // Table-driven vectors
    foreach (vecs[i]) begin
      load_mem(vecs[i].w, vecs[i].x, vecs[i].only0);
      apply_stimulus(vecs[i].name, vecs[i].b, vecs[i].exp_r, vecs[i].exp_l);
      tick();
    end

    // Backpressure with a START pulse while waiting
    load_mem(16'h0100, 16'h0100, 1'b0);
    y_ready = 1'b0;
    bias = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(cyc, addr_err);
    check_output("bp_latency", 32'(cyc), 32'd30);
    check_output("bp_y", 32'(bus_r.y), 32'h1C00);
    err = 0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      tick();
      if (bus_r.y !== 16'h1C00 || bus_r.y_valid !== 1'b1 || bus_r.en !== 1'b0 ||
          bus_r.addr !== 5'd0 || bus_r.busy !== 1'b1) err++;
    end
    start = 1'b0;
    check_output("bp_stable", 32'(err), 32'd0);
    y_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("bp_xfer", 32'({bus_r.busy, bus_r.y_valid, bus_r.en}), 32'd0);
    tick();
    check_output("xfer_start_ignored", 32'({bus_r.busy, bus_r.en}), 32'd0);

    // START held high restarts on each entry to IDLE
    start = 1'b1;
    tick();
    wait_valid(cyc, addr_err);
    check_output("held_latency", 32'(cyc), 32'd30);
    tick();
    check_output("held_idle", 32'(bus_r.busy), 32'd0);
    tick();
    start = 1'b0;
    check_output("held_restart", 32'({bus_r.busy, bus_r.en, bus_r.addr}), 32'({1'b1, 1'b1, 5'd0}));
    wait_valid(cyc, addr_err);
    check_output("held_y", 32'(bus_r.y), 32'h1C00);
    tick();

    // Reset during a job aborts it
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("rst_abort", 32'({bus_r.en, bus_r.busy, bus_r.y_valid}), 32'd0);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_r.y_valid || bus_l.y_valid || bus_r.en) hits++;
    end
    check_output("rst_no_valid", 32'(hits), 32'd0);
    apply_stimulus("after_rst", 16'h0000, 16'h1C00, 16'h1C00);

    // Single-input instance: latency 3
    w_mem[0] = 16'h0200;
    x_mem[0] = 16'h0180;
    bias = 16'h0000;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    check_output("small_en", 32'({bus_s.en, bus_s.addr}), 32'({1'b1, 5'd0}));
    cyc = 0;
    while (!bus_s.y_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check_output("small_latency", 32'(cyc), 32'd3);
    check_output("small_y", 32'(bus_s.y), 32'h0300);
    tick();
    check_output("small_xfer", 32'({bus_s.busy, bus_s.y_valid}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
